node_frame_streamer: RTL

NODE_FRAME_STREAMER -- requirements
Module: node_frame_streamer

---
 rtl/node_frame_streamer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/node_frame_streamer.sv
// Snapshots TOTAL_NODES x/y node positions on request and streams them one word per
// accepted handshake, with frame and dropped-request counters.
module node_frame_streamer #(
  parameter int unsigned TOTAL_NODES = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [TOTAL_NODES*32-1:0]   nodes_x,
  input  logic [TOTAL_NODES*32-1:0]   nodes_y,
  input  logic                        frame_req,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [31:0]                 out_x,
  output logic [31:0]                 out_y,
  output logic [7:0]                  out_index,
  output logic                        out_last,
  output logic                        busy,
  output logic [15:0]                 frame_count,
  output logic [15:0]                 dropped_count
);

  localparam int unsigned W        = 32;
  localparam int unsigned VW       = TOTAL_NODES * W;
  localparam logic [7:0]  LAST_IDX = 8'(TOTAL_NODES - 1);
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t        state, state_n;
  logic [VW-1:0] snap_x, snap_y;
  logic [7:0]    index, index_n;
  logic          snap_load;
  logic          xfer, xfer_last;
  logic          valid_n, last_n;
  logic [W-1:0]  x_n, y_n;
  logic [15:0]   fc_n, dc_n;

  // Next-state, counter and next-output-word selection
  always_comb begin
    state_n   = state;
    index_n   = index;
    snap_load = 1'b0;
    fc_n      = frame_count;
    dc_n      = dropped_count;
    x_n       = '0;
    y_n       = '0;
    xfer      = (state == STREAM) && out_ready;
    xfer_last = xfer && (index == LAST_IDX);

    case (state)
      IDLE: begin
        if (frame_req) begin
          snap_load = 1'b1;
          index_n   = 8'd0;
          state_n   = STREAM;
        end
      end
      STREAM: begin
        if (xfer_last) begin
          fc_n    = (frame_count == CNT_MAX) ? frame_count : frame_count + 16'd1;
          index_n = 8'd0;
          // A request coinciding with the final transfer restarts without a bubble
          if (frame_req) snap_load = 1'b1;
          else           state_n   = IDLE;
        end else begin
          if (frame_req)
            dc_n = (dropped_count == CNT_MAX) ? dropped_count : dropped_count + 16'd1;
          if (xfer)
            index_n = index + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    valid_n = (state_n == STREAM);
    last_n  = valid_n && (index_n == LAST_IDX);

    // Fresh frames read straight from the inputs; otherwise from the snapshot
    if (snap_load) begin
      x_n = nodes_x[W-1:0];
      y_n = nodes_y[W-1:0];
    end else if (valid_n) begin
      x_n = W'(snap_x >> (W * index_n));
      y_n = W'(snap_y >> (W * index_n));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      index         <= 8'd0;
      snap_x        <= '0;
      snap_y        <= '0;
      out_valid     <= 1'b0;
      busy          <= 1'b0;
      out_x         <= '0;
      out_y         <= '0;
      out_index     <= 8'd0;
      out_last      <= 1'b0;
      frame_count   <= 16'd0;
      dropped_count <= 16'd0;
    end else begin
      state         <= state_n;
      index         <= index_n;
      if (snap_load) begin
        snap_x <= nodes_x;
        snap_y <= nodes_y;
      end
      out_valid     <= valid_n;
      busy          <= valid_n;
      out_x         <= x_n;
      out_y         <= y_n;
      out_index     <= index_n;
      out_last      <= last_n;
      frame_count   <= fc_n;
      dropped_count <= dc_n;
    end
  end

endmodule
